// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcodes, flag indices, sequencer states and
//                instruction field helpers for the ALU issue sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    localparam int FL_C  = 0;
    localparam int FL_V  = 1;
    localparam int FL_DZ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    function automatic logic [3:0] instr_op(input logic [INSTR_W-1:0] instr);
        return instr[15:12];
    endfunction

    function automatic logic [2:0] instr_rd(input logic [INSTR_W-1:0] instr);
        return instr[11:9];
    endfunction

    function automatic logic [2:0] instr_rs(input logic [INSTR_W-1:0] instr);
        return instr[8:6];
    endfunction

    function automatic logic [2:0] instr_rt(input logic [INSTR_W-1:0] instr);
        return instr[5:3];
    endfunction

    // Opcodes 1..9 update architectural state; everything else is a NOP.
    function automatic logic is_arch_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_CMP);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/regfile_8x16.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_8x16
//  Description : 8-entry register file, one synchronous write port, two
//                asynchronous operand reads and one debug read. r0 is
//                hardwired to zero and silently drops writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_8x16 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [2:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] w_regs [8];

    for (genvar i = 0; i < 8; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign w_regs[i] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] r_q;

            // Storage for one architectural register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (we && (waddr == 3'(i))) begin
                    r_q <= wdata;
                end
            end

            assign w_regs[i] = r_q;
        end
    end

    assign rdata_a  = w_regs[raddr_a];
    assign rdata_b  = w_regs[raddr_b];
    assign dbg_data = w_regs[dbg_addr];

endmodule : regfile_8x16
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : Single-issue sequencer feeding an external 16-bit ALU.
//                IDLE accepts a preload or an instruction, EXEC samples the
//                ALU result, WB commits it to the register file and the
//                architectural flag / HI registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [2:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ins,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] alu_hi,
    input  logic [2:0]        alu_flags,
    output logic              done,
    output logic              err,
    output logic [2:0]        flags_q,
    output logic [DATA_W-1:0] hi_q,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_op;
    logic [2:0]        r_rd;
    logic [DATA_W-1:0] r_res_q;
    logic [DATA_W-1:0] r_hi_t;
    logic [2:0]        r_fl_t;

    logic              w_accept;
    logic              w_arch_op;
    logic              w_div_err;
    logic              w_we;
    logic [2:0]        w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    assign w_arch_op = is_arch_op(r_op);
    assign w_div_err = (r_op == OP_DIV) && r_fl_t[FL_DZ];

    // Operands are read combinationally from the incoming instruction so they
    // are captured on the accepting edge, ahead of any later writeback.
    regfile_8x16 #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (w_we),
        .waddr    (w_waddr),
        .wdata    (w_wdata),
        .raddr_a  (instr_rs(in_instr)),
        .rdata_a  (w_rs_data),
        .raddr_b  (instr_rt(in_instr)),
        .rdata_b  (w_rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, handshakes and the shared write port (preload in IDLE,
    // writeback in WB, so the two never collide).
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        ld_ready     = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        w_accept     = 1'b0;
        w_we         = 1'b0;
        w_waddr      = ld_addr;
        w_wdata      = ld_data;
        case (r_state)
            IDLE: begin
                ld_ready = 1'b1;
                in_ready = !ld_valid;
                if (ld_valid) begin
                    w_we = 1'b1;
                end else if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = WB;
            end
            WB: begin
                done = 1'b1;
                err  = w_div_err;
                if (w_arch_op && !w_div_err) begin
                    w_we    = 1'b1;
                    w_waddr = r_rd;
                    w_wdata = r_res_q;
                end
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, ALU result sampling, flag/HI commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= OP_NOP;
            r_rd    <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_ins <= OP_NOP;
            r_res_q <= '0;
            r_hi_t  <= '0;
            r_fl_t  <= '0;
            flags_q <= '0;
            hi_q    <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= instr_op(in_instr);
                r_rd    <= instr_rd(in_instr);
                alu_a   <= w_rs_data;
                alu_b   <= w_rt_data;
                alu_ins <= instr_op(in_instr);
            end
            if (r_state == EXEC) begin
                r_res_q <= alu_out;
                r_hi_t  <= alu_hi;
                r_fl_t  <= alu_flags;
            end
            if ((r_state == WB) && w_arch_op) begin
                flags_q <= r_fl_t;
                if (r_op == OP_MUL) begin
                    hi_q <= r_hi_t;
                end
            end
        end
    end

endmodule : alu_issue
`default_nettype wire

// File: doc/alu_issue.md
# alu_issue

Single-issue sequencer directly upstream of the 16-bit `alu`. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an 8×16 register file. It drives the registered operands and opcode into `alu`, then captures `out`/`hi`/`flags` and writes the result back. Sequential operation, one instruction in flight.

## Interface
- `DATA_W`, 16: datapath width. Fixed by the ALU; instruction format assumes 16.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: `state==IDLE && !ld_valid`.
- `in_instr` in 16: `op[15:12]`, `rd[11:9]`, `rs[8:6]`, `rt[5:3]`; bits `[2:0]` ignored.
- `ld_valid` in 1: register preload request.
- `ld_ready` out 1: `state==IDLE`.
- `ld_addr` in 3, `ld_data` in 16: preload target and value.
- `alu_a`, `alu_b` out 16: registered operands to `alu` `A`/`B`.
- `alu_ins` out 4: registered opcode to `alu` `ins`.
- `alu_out`, `alu_hi` in 16: from `alu` `out`/`hi`.
- `alu_flags` in 3: from `alu` `flags`; bit 0 carry, 1 overflow, 2 divide error.
- `done` out 1: one-cycle pulse in WB.
- `err` out 1: one-cycle pulse in WB when a divide error suppressed writeback.
- `flags_q` out 3: architectural flag register.
- `hi_q` out 16: architectural HI register.
- `dbg_addr` in 3, `dbg_data` out 16: combinational register-file read.

## Operation
- Register file `r0..r7`. `r0` reads 0 and ignores writes, including via preload.
- States:
  - **IDLE**: on `ld_valid`, write `ld_data` to `ld_addr`; the instruction is not accepted that cycle. Otherwise, on `in_valid && in_ready`, capture `op`/`rd` and `alu_a<=R[rs]`, `alu_b<=R[rt]`, `alu_ins<=op`, then go to EXEC.
  - **EXEC**: sample `alu_out`, `alu_hi`, `alu_flags` into `res_q`, `hi_t`, `fl_t`. Go to WB.
  - **WB**: writeback rules below; pulse `done`; go to IDLE.
- Writeback rules by op:
  - 1–9 (add, sub, mul, div, or, and, not, xor, cmp): `R[rd]<=res_q` and `flags_q<=fl_t`.
  - Exception: op 4 with `fl_t[2]=1` leaves `R[rd]` unchanged, sets `flags_q<=fl_t`, pulses `err`.
  - op 3 additionally does `hi_q<=hi_t`. No other op touches `hi_q`.
  - op 0 and 10–15 are NOPs: no register, flag or HI update; `done` still pulses.
- `alu_a`/`alu_b`/`alu_ins` hold their values from handshake until the next accepted instruction.
- `ld_valid` outside IDLE is ignored (`ld_ready=0`); the requester must hold it.
- `rd==rs` and the other aliasing cases are legal. Operands are read in IDLE, before any writeback.

## Timing
- Handshake edge N, ALU inputs valid after N, sampled at N+1, writeback and `done` during cycle N+2 (committed at its end). `in_ready` high again at N+3.
- Throughput is one instruction per 3 cycles; latency from accept to visible register is 3 edges.
- `dbg_data` reflects a writeback on the cycle after the WB edge.
- Reset values:
  - State IDLE.
  - All registers, `alu_a`/`alu_b`/`alu_ins`, `flags_q`, `hi_q`, `res_q` are 0.
  - `done` and `err` are 0.
- Reset asserted mid-instruction aborts it: no writeback, no `done`, and the instruction is lost.
- `in_valid` may drop before acceptance without penalty. `in_instr` must be stable only on the accepting edge.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `OP_NOP=0`, `OP_ADD=1`, `OP_SUB=2`, `OP_MUL=3`, `OP_DIV=4`, `OP_OR=5`, `OP_AND=6`, `OP_NOT=7`, `OP_XOR=8`, `OP_CMP=9`
  - flag bit indices `FL_C=0`, `FL_V=1`, `FL_DZ=2`
  - state enum `IDLE/EXEC/WB`
  - instruction field slices
- One natural sub-module: `regfile_8x16`, with one sync write port, two async read ports plus a debug read, and `r0` hardwired.
- `alu` is instantiated beside this block by the top level, not inside it.

## Test plan
- Preload `r1=0x7FFF`, `r2=0x0001`; issue `add r3,r1,r2` → `r3=0x8000`, `flags_q=3'b010`, `done` exactly 2 cycles after accept.
- Preload `r1=0x0100`, `r2=0x0100`; issue `mul r4,r1,r2` → `r4=0x0000`, `hi_q=0x0001`; a following `add` leaves `hi_q=0x0001`.
- Preload `r5=0x1234`, `r1=7`; issue `div r5,r1,r0` → `r5` stays `0x1234`, `flags_q[2]=1`, `err` and `done` both pulse once.
- Issue op 12 with `flags_q=3'b010` → no register change, `flags_q` unchanged, `done` pulses; also `ld_valid` with `ld_addr=0` → `r0` still reads 0.
- Hold `in_valid` with back-to-back instructions → accepts exactly every 3 cycles; assert `ld_valid` during EXEC → `ld_ready=0`, preload lands only after return to IDLE.
- Drop `rst_n` during EXEC of `add r3,...` → `r3=0`, `done` never pulses, `in_ready=1` on the first cycle after release.
